// File: rtl/dmem_pkg.sv
// Shared constants for the data memory responder: MMIO base, register offsets, STATUS bit positions.
package dmem_pkg;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CYCLE  = 4'h8;
    localparam logic [3:0] OFF_COUNT  = 4'hC;

    localparam int STATUS_EMPTY = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_OVF   = 2;

    // Register select ignores the byte-within-word bits.
    function automatic logic [3:0] mmio_offset(input logic [31:0] addr);
        return {addr[3:2], 2'b00};
    endfunction
endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO for the MMIO transmit path; head is visible one cycle after a push (no bypass).
// A push while full succeeds only when a pop happens on the same edge; otherwise it is dropped.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         data
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    assign data = empty ? '0 : store[rd_ptr];
endmodule

// File: rtl/data_mem_responder.sv
// Data memory with combinational reads, byte-lane writes and registered mem_err; DMEM_MMIO_EN adds an MMIO
// TX FIFO (tx_valid/tx_ready, stalls while tx_ready=0) and cycle counter, otherwise the MMIO window is unmapped.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_err
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic          is_ram;
    logic          is_mmio;
    logic          unmapped;
    logic [31:0]   mmio_rdata;

    assign widx     = daddr[AW+1:2];
    assign is_ram   = ({1'b0, daddr} < RAM_BYTES);
    assign unmapped = !is_ram && !is_mmio;

    always_ff @(posedge clk) begin
        if (is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) ram[widx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mem_err <= 1'b0;
        else          mem_err <= unmapped;
    end

    always_comb begin
        drdata = '0;
        if (is_ram)       drdata = ram[widx];
        else if (is_mmio) drdata = mmio_rdata;
    end

`ifdef DMEM_MMIO_EN
    logic [31:0]                 cycle;
    logic [3:0]                  off;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic                        overflow;
    logic                        ovf_set;
    logic                        ovf_clr;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign is_mmio  = !is_ram && (daddr[31:4] == MMIO_BASE[31:4]);
    assign off      = mmio_offset(daddr);
    assign push     = is_mmio && (off == OFF_TXDATA) && dwe[0];
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = !empty;
    assign ovf_set  = push && full && !pop;
    assign ovf_clr  = is_mmio && (off == OFF_STATUS) && dwe[0] && dwdata[STATUS_OVF];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cycle <= '0;
        else          cycle <= cycle + 32'd1;
    end

    // A simultaneous set wins over software clear so no drop goes unreported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (dwdata[7:0]),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .data      (tx_data)
    );

    always_comb begin
        mmio_rdata = '0;
        case (off)
            OFF_STATUS: begin
                mmio_rdata[STATUS_EMPTY] = empty;
                mmio_rdata[STATUS_FULL]  = full;
                mmio_rdata[STATUS_OVF]   = overflow;
            end
            OFF_CYCLE: mmio_rdata = cycle;
            OFF_COUNT: mmio_rdata = 32'(fifo_count);
            default:   mmio_rdata = '0;
        endcase
    end
`else
    logic unused_cfg;

    assign is_mmio    = 1'b0;
    assign mmio_rdata = '0;
    assign tx_valid   = 1'b0;
    assign tx_data    = '0;
    assign unused_cfg = ^{tx_ready, MMIO_BASE, 32'(FIFO_DEPTH)};
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: RAM/decode vector table plus FIFO, overflow and reset sequences.
module tb_data_mem_responder;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        bit          chk;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vt [$];

    data_mem_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mem_err  (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we);
        daddr  = a;
        dwdata = w;
        dwe    = we;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 4'h0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(a, 32'h0, 4'h0);
        @(negedge clk);
        check(name, drdata, exp);
        tick();
        idle();
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        drive(MB, {24'h0, b}, 4'h1);
        if (accept) sb.push_back(b);
        tick();
        idle();
    endtask

    function automatic void add(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we,
                                input bit chk, input logic [31:0] rd, input logic err);
        vec_t v;
        v.addr = a; v.wdata = w; v.we = we; v.chk = chk; v.exp_rd = rd; v.exp_err = err;
        vt.push_back(v);
    endfunction

    // Scoreboard: every handshake must deliver the oldest accepted byte.
    always @(posedge clk) begin
        if (reset_n && tx_valid && tx_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL tx_pop_unexpected: got 0x%02h, expected no byte", tx_data);
            end else begin
                mon_exp = sb.pop_front();
                if (tx_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", tx_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;

        add(32'h10,        32'hDEADBEEF, 4'hF, 0, 32'h0,        0);
        add(32'h10,        32'h000000AA, 4'h1, 1, 32'hDEADBEEF, 0);
        add(32'h10,        32'h0,        4'h0, 1, 32'hDEADBEAA, 0);
        add(32'h13,        32'h0,        4'h0, 1, 32'hDEADBEAA, 0);
        add(32'h20,        32'h12345678, 4'hF, 0, 32'h0,        0);
        add(32'h20,        32'h0000AB00, 4'h2, 1, 32'h12345678, 0);
        add(32'h20,        32'hCD000000, 4'h8, 1, 32'h1234AB78, 0);
        add(32'h20,        32'h0,        4'h0, 1, 32'hCD34AB78, 0);
        add(32'hFFC,       32'h0BADF00D, 4'hF, 0, 32'h0,        0);
        add(32'hFFC,       32'h0,        4'h0, 1, 32'h0BADF00D, 0);
        add(32'h1000,      32'h0,        4'h0, 1, 32'h0,        1);
        add(32'h10,        32'h0,        4'h0, 1, 32'hDEADBEAA, 0);
        add(32'h0001_0000, 32'h0,        4'h0, 1, 32'h0,        1);
        add(32'h0001_0010, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        1);
        add(32'h10,        32'h0,        4'h0, 1, 32'hDEADBEAA, 0);
        add(32'h0FFF_FFFC, 32'h0,        4'h0, 1, 32'h0,        1);
`ifdef DMEM_MMIO_EN
        add(MB + 32'h8,    32'hFFFFFFFF, 4'hF, 0, 32'h0,        0);
        add(MB + 32'hC,    32'hFFFFFFFF, 4'hF, 0, 32'h0,        0);
        add(MB,            32'h0,        4'h0, 1, 32'h0,        0);
        add(MB + 32'hC,    32'h0,        4'h0, 1, 32'h0,        0);
        add(MB + 32'h4,    32'h0,        4'h0, 1, 32'h1,        0);
        add(MB + 32'h10,   32'h0,        4'h0, 1, 32'h0,        1);
`else
        add(MB + 32'h8,    32'h0,        4'h0, 1, 32'h0,        1);
        add(MB,            32'hFF,       4'h1, 1, 32'h0,        1);
        add(32'h10,        32'h0,        4'h0, 1, 32'hDEADBEAA, 0);
`endif

        reset_n  = 1'b0;
        tx_ready = 1'b0;
        idle();
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data",  32'(tx_data),  32'h0);
        check("rst_mem_err",  32'(mem_err),  32'h0);
`ifdef DMEM_MMIO_EN
        daddr = MB + 32'h8;
        @(negedge clk);
        check("rst_cycle", drdata, 32'h0);
        idle();
`endif
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            drive(vt[i].addr, vt[i].wdata, vt[i].we);
            @(negedge clk);
            if (vt[i].chk) check($sformatf("vec%0d_rdata", i), drdata, vt[i].exp_rd);
            tick();
            check($sformatf("vec%0d_mem_err", i), 32'(mem_err), 32'(vt[i].exp_err));
        end
        idle();
        tick();
        check("mem_err_idle", 32'(mem_err), 32'h0);

`ifdef DMEM_MMIO_EN
        daddr = MB + 32'h8;
        @(negedge clk);
        c1 = drdata;
        repeat (5) @(negedge clk);
        c2 = drdata;
        check("cycle_delta", c2 - c1, 32'd5);
        tick();
        idle();

        // Three bytes queued with the consumer stalled, then drained in order.
        drive(MB, 32'h41, 4'h1);
        sb.push_back(8'h41);
        @(negedge clk);
        check("push_empty_no_bypass", 32'(tx_valid), 32'h0);
        tick();
        idle();
        check("tx_valid_next_cycle", 32'(tx_valid), 32'h1);
        push(8'h42, 1);
        push(8'h43, 1);
        rd_chk("count3", MB + 32'hC, 32'd3);
        check("head_41", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        repeat (3) tick();
        tx_ready = 1'b0;
        check("drain3_tx_valid", 32'(tx_valid), 32'h0);
        check("drain3_sb_empty", 32'(sb.size()), 32'h0);
        rd_chk("status_empty", MB + 32'h4, 32'h1);

        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1);
        rd_chk("status_full", MB + 32'h4, 32'h2);
        rd_chk("count_full", MB + 32'hC, 32'd8);
        push(8'h99, 0);
        rd_chk("status_overflow", MB + 32'h4, 32'h6);
        check("head_after_drop", 32'(tx_data), 32'h10);
        drive(MB + 32'h4, 32'h4, 4'h1);
        tick();
        idle();
        rd_chk("status_ovf_cleared", MB + 32'h4, 32'h2);

        // Push into a full FIFO on the same edge as a pop.
        tx_ready = 1'b1;
        drive(MB, 32'h55, 4'h1);
        sb.push_back(8'h55);
        tick();
        tx_ready = 1'b0;
        idle();
        rd_chk("count_push_pop_full", MB + 32'hC, 32'd8);
        rd_chk("status_no_ovf", MB + 32'h4, 32'h2);
        tx_ready = 1'b1;
        repeat (8) tick();
        tx_ready = 1'b0;
        check("drain8_tx_valid", 32'(tx_valid), 32'h0);
        check("drain8_sb_empty", 32'(sb.size()), 32'h0);

        // Reset while draining with five entries left.
        for (int i = 0; i < 7; i++) push(8'h60 + 8'(i), 1);
        tx_ready = 1'b1;
        repeat (2) tick();
        daddr = MB + 32'hC;
        #2;
        check("count5_before_reset", drdata, 32'd5);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_tx_data",  32'(tx_data),  32'h0);
        check("reset_count",    drdata,        32'h0);
        daddr = MB + 32'h8;
        #1;
        check("reset_cycle", drdata, 32'h0);
        @(negedge clk);
        tx_ready = 1'b0;
        reset_n  = 1'b1;
        idle();
        tick();
        rd_chk("ram_retained", 32'h10, 32'hDEADBEAA);
        check("post_reset_tx_valid", 32'(tx_valid), 32'h0);
`else
        tx_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_tx_data",  32'(tx_data),  32'h0);
        @(negedge clk);
        tx_ready = 1'b0;
        reset_n  = 1'b1;
        tick();
        rd_chk("ram_retained", 32'h10, 32'hDEADBEAA);
        check("post_reset_mem_err", 32'(mem_err), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
